avalon_frame_regbank: RTL
=========================

Name: avalon_frame_regbank

Overview:
- Parametrised Avalon-MM register bank between the Nios and the game/display logic (cube map, Qbert, saucer).
- Writable control registers are double-buffered as shadow and active copies. Active values update either immediately or atomically at a frame boundary.
- Read-only status inputs are snapshotted once per frame, so software always reads a coherent set.
- Supports self-clearing strobe registers, byte enables, and a frame/status-change interrupt.

Parameters:
- N_CTRL, 16, number of control registers (shadow + active), word addresses 0..N_CTRL-1.
- N_STAT, 16, number of status registers, word addresses N_CTRL..N_CTRL+N_STAT-1.
- DATA_W, 32, register and bus data width; must be a multiple of 8.
- ADDR_W, 8, Avalon word-address width; requires N_CTRL+N_STAT+2 <= 2**ADDR_W.
- PULSE_MASK, {N_CTRL{1'b0}}, bit k=1 makes control register k a one-cycle strobe.

Ports:
- Avalon_CLK_50  in  1  bus/system clock; all logic in this domain.
- iRST_n  in  1  asynchronous active-low reset.
- Avalon_address  in  ADDR_W  word address.
- Avalon_read  in  1  read strobe.
- Avalon_write  in  1  write strobe.
- Avalon_byteenable  in  DATA_W/8  per-byte write enables.
- Avalon_writedata  in  DATA_W  write data.
- Avalon_readdata  out  DATA_W  read data, fixed latency 1.
- Avalon_irq  out  1  level interrupt.
- iFrameToggle  in  1  toggles once per LCD frame, sourced from the iCLK domain; asynchronous here.
- iStat  in  N_STAT*DATA_W  status words, register j at bits [j*DATA_W +: DATA_W].
- oCtrl  out  N_CTRL*DATA_W  active control words, same packing as iStat.
- oCommitPulse  out  1  high for the single cycle in which oCtrl takes newly committed values.

Behaviour:
- Reset, decided: reset iRST_n, asynchronous, active-low; clock Avalon_CLK_50.
- During reset, all of the following are 0: shadow, active, snapshot, CFG, IRQ_STAT, Avalon_readdata, Avalon_irq, oCommitPulse, and the synchroniser flops.
- Address map:
  - Control shadow: 0..N_CTRL-1, R/W.
  - Status snapshot: N_CTRL..N_CTRL+N_STAT-1, RO.
  - CFG at A_CFG = N_CTRL+N_STAT:
    - bit0 mode: 0 = immediate, 1 = frame-synchronous.
    - bit1 irq_en_frame.
    - bit2 irq_en_stat.
    - bit3 commit_req: write 1 to set; writing 0 has no effect; reads back 1 while pending.
  - IRQ_STAT at A_CFG+1, W1C:
    - bit0 frame_seen.
    - bit1 stat_changed.
  - All other addresses: writes ignored, reads return 0.
- Writes: shadow_k <= (shadow_k & ~mask) | (wdata & mask), where mask is byteenable expanded to bytes. CFG and IRQ_STAT also honour byte lane 0.
- Reads: Avalon_readdata is registered on the cycle after Avalon_read and holds its value until the next read. Simultaneous read and write of the same address returns the pre-write value.
- Frame tick:
  - iFrameToggle passes through a 2-flop synchroniser, then a third flop for edge detection.
  - tick = s2 ^ s3, a one-cycle pulse 3 cycles after the toggle edge.
  - Toggle edges closer together than 3 Avalon cycles are not required to be resolved.
- On tick:
  - snapshot <= iStat.
  - frame_seen <= 1.
  - stat_changed <= 1 if the new snapshot differs from the previous one.
- Commit, immediate mode: a write to control k updates active_k with the merged value in the same clock edge as the shadow; oCommitPulse=1 that cycle.
- Commit, frame mode: on tick with commit_req=1, active <= shadow for all k, commit_req <= 0, oCommitPulse=1. On tick with commit_req=0, active is unchanged.
- Commit in the same cycle as a shadow write (frame mode): the commit uses the pre-write shadow; the write stays in shadow for the next commit.
- commit_req set by a write in the same cycle as a tick: the tick consumes the existing request state, and the new set survives, so commit_req=1 afterwards.
- Strobes (PULSE_MASK[k]=1): active_k holds its value for exactly one cycle after the commit, then both active_k and shadow_k clear to 0. Re-writing the strobe while it is high restarts it.
- Mode switch 1->0 with commit_req pending: commit_req clears and active is untouched until the next control write.
- IRQ_STAT: W1C clears bits. A set and a clear of the same bit in the same cycle leaves the bit set.
- Avalon_irq = (frame_seen & irq_en_frame) | (stat_changed & irq_en_stat), registered.
- Asynchronous reset mid-frame or mid-commit returns every register to its reset value immediately; no partial commit survives.

Test Plan:
- Reset, then write 0x1234 to addr 3 (mode 0, byteenable 4'hF) -> oCtrl[3] = 0x1234 and oCommitPulse=1 on the same edge. Read addr 3 -> readdata 0x1234 one cycle after read.
- Mode 1: write addr 0 = 0xAA, write CFG = 0x9, toggle iFrameToggle -> oCtrl[0] stays 0 until 3 cycles after the toggle, then becomes 0xAA with a 1-cycle oCommitPulse; CFG reads 0x1. A second toggle gives no pulse.
- Byteenable: addr 1 = 0xFFFFFFFF, then write 0x00000000 with byteenable 4'b0101 -> readback 0xFF00FF00.
- PULSE_MASK=16'h0002, mode 0: write addr 1 = 1 -> oCtrl[1] = 1 for exactly 1 cycle, then 0; addr 1 reads 0.
- iStat[0] = 5, CFG = 0x4, toggle -> snapshot addr N_CTRL reads 5, IRQ_STAT = 0x3, Avalon_irq = 1. Write IRQ_STAT = 0x2 -> irq drops; a toggle with iStat unchanged leaves stat_changed = 0.
- Frame mode: shadow write on the exact tick cycle -> committed value is the old shadow; the new value appears after the next commit_req + toggle. Assert iRST_n low mid-sequence -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/avalon_frame_regbank.sv
// avalon_frame_regbank
//   Avalon-MM register bank between the Nios and the game/display logic.
//   Control registers are double-buffered (shadow written by software,
//   active driven to the logic). Active copies follow writes immediately
//   or are committed atomically on the next frame tick. Status inputs are
//   snapshotted once per frame so software always reads a coherent set.
//
// Ports
//   Avalon_CLK_50      in   system clock, all logic in this domain
//   iRST_n             in   asynchronous active-low reset
//   Avalon_address     in   word address
//   Avalon_read        in   read strobe (readdata valid next cycle)
//   Avalon_write       in   write strobe
//   Avalon_byteenable  in   per-byte write enables
//   Avalon_writedata   in   write data
//   Avalon_readdata    out  registered read data, held until next read
//   Avalon_irq         out  level interrupt (frame seen / status changed)
//   iFrameToggle       in   toggles once per LCD frame (asynchronous)
//   iStat              in   packed status words, word j at [j*DATA_W +: DATA_W]
//   oCtrl              out  packed active control words, same packing
//   oCommitPulse       out  high in the cycle oCtrl takes committed values
module avalon_frame_regbank #(
    parameter int unsigned       N_CTRL     = 16,
    parameter int unsigned       N_STAT     = 16,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ADDR_W     = 8,
    parameter logic [N_CTRL-1:0] PULSE_MASK = '0
) (
    input  logic                     Avalon_CLK_50,
    input  logic                     iRST_n,
    input  logic [ADDR_W-1:0]        Avalon_address,
    input  logic                     Avalon_read,
    input  logic                     Avalon_write,
    input  logic [DATA_W/8-1:0]      Avalon_byteenable,
    input  logic [DATA_W-1:0]        Avalon_writedata,
    output logic [DATA_W-1:0]        Avalon_readdata,
    output logic                     Avalon_irq,
    input  logic                     iFrameToggle,
    input  logic [N_STAT*DATA_W-1:0] iStat,
    output logic [N_CTRL*DATA_W-1:0] oCtrl,
    output logic                     oCommitPulse
);

    localparam int unsigned       NBYTES = DATA_W / 8;
    localparam logic [ADDR_W-1:0] A_CFG  = ADDR_W'(N_CTRL + N_STAT);
    localparam logic [ADDR_W-1:0] A_IRQ  = ADDR_W'(N_CTRL + N_STAT + 1);

    logic [DATA_W-1:0] shadow_q [N_CTRL];
    logic [DATA_W-1:0] shadow_d [N_CTRL];
    logic [DATA_W-1:0] active_q [N_CTRL];
    logic [DATA_W-1:0] active_d [N_CTRL];
    logic [DATA_W-1:0] snap_q   [N_STAT];
    logic [DATA_W-1:0] snap_d   [N_STAT];
    logic [N_CTRL-1:0] live_q, live_d;
    logic [2:0]        cfg_q, cfg_d;
    logic              commit_req_q, commit_req_d;
    logic              frame_seen_q, frame_seen_d;
    logic              stat_changed_q, stat_changed_d;
    logic              irq_q, irq_d;
    logic              pulse_q, pulse_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              sync1_q, sync2_q, sync3_q;

    logic [DATA_W-1:0]        wmask;
    logic [DATA_W-1:0]        merged;
    logic [N_STAT*DATA_W-1:0] snap_flat;
    logic                     tick;
    logic                     commit_frame;
    logic                     cfg_wr;
    logic                     irq_wr;
    logic                     wr_k;

    assign tick         = sync2_q ^ sync3_q;
    assign commit_frame = tick & cfg_q[0] & commit_req_q;
    assign cfg_wr       = Avalon_write && (Avalon_address == A_CFG) && Avalon_byteenable[0];
    assign irq_wr       = Avalon_write && (Avalon_address == A_IRQ) && Avalon_byteenable[0];

    always_comb begin
        wmask = '0;
        for (int unsigned b = 0; b < NBYTES; b++)
            wmask[b*8 +: 8] = {8{Avalon_byteenable[b]}};
    end

    always_comb begin
        snap_flat = '0;
        for (int unsigned j = 0; j < N_STAT; j++)
            snap_flat[j*DATA_W +: DATA_W] = snap_q[j];
    end

    // Control registers. Later assignments take priority: a fresh commit
    // overrides the strobe self-clear, and a shadow write overrides the
    // shadow self-clear so a re-written strobe restarts.
    always_comb begin
        pulse_d = commit_frame;
        merged  = '0;
        wr_k    = 1'b0;
        for (int unsigned k = 0; k < N_CTRL; k++) begin
            wr_k        = Avalon_write && (Avalon_address == ADDR_W'(k));
            merged      = (shadow_q[k] & ~wmask) | (Avalon_writedata & wmask);
            shadow_d[k] = shadow_q[k];
            active_d[k] = active_q[k];
            live_d[k]   = 1'b0;
            if (PULSE_MASK[k] && live_q[k]) begin
                active_d[k] = '0;
                if (!wr_k)
                    shadow_d[k] = '0;
            end
            if (wr_k)
                shadow_d[k] = merged;
            if (wr_k && !cfg_q[0]) begin
                active_d[k] = merged;
                live_d[k]   = PULSE_MASK[k];
                pulse_d     = 1'b1;
            end
            // Commit takes the pre-write shadow; a same-cycle write waits
            // in the shadow for the following commit.
            if (commit_frame) begin
                active_d[k] = shadow_q[k];
                live_d[k]   = PULSE_MASK[k];
            end
        end
    end

    // CFG, commit request, IRQ status, snapshot.
    always_comb begin
        cfg_d = cfg_q;
        if (cfg_wr)
            cfg_d = Avalon_writedata[2:0];

        // Tick consumes the old request first, so a same-cycle set survives.
        commit_req_d = commit_req_q;
        if (commit_frame)
            commit_req_d = 1'b0;
        if (cfg_wr && Avalon_writedata[3])
            commit_req_d = 1'b1;
        if (!cfg_d[0])
            commit_req_d = 1'b0;

        frame_seen_d = frame_seen_q;
        if (irq_wr && Avalon_writedata[0])
            frame_seen_d = 1'b0;
        if (tick)
            frame_seen_d = 1'b1;

        stat_changed_d = stat_changed_q;
        if (irq_wr && Avalon_writedata[1])
            stat_changed_d = 1'b0;
        if (tick && (iStat != snap_flat))
            stat_changed_d = 1'b1;

        for (int unsigned j = 0; j < N_STAT; j++)
            snap_d[j] = tick ? iStat[j*DATA_W +: DATA_W] : snap_q[j];

        irq_d = (frame_seen_q & cfg_q[1]) | (stat_changed_q & cfg_q[2]);
    end

    // Read mux uses current register values, so read-during-write returns
    // the pre-write contents.
    always_comb begin
        rdata_d = rdata_q;
        if (Avalon_read) begin
            rdata_d = '0;
            for (int unsigned k = 0; k < N_CTRL; k++)
                if (Avalon_address == ADDR_W'(k))
                    rdata_d = shadow_q[k];
            for (int unsigned j = 0; j < N_STAT; j++)
                if (Avalon_address == ADDR_W'(N_CTRL + j))
                    rdata_d = snap_q[j];
            if (Avalon_address == A_CFG)
                rdata_d[3:0] = {commit_req_q, cfg_q};
            if (Avalon_address == A_IRQ)
                rdata_d[1:0] = {stat_changed_q, frame_seen_q};
        end
    end

    always_ff @(posedge Avalon_CLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            for (int unsigned k = 0; k < N_CTRL; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
            for (int unsigned j = 0; j < N_STAT; j++)
                snap_q[j] <= '0;
            live_q         <= '0;
            cfg_q          <= '0;
            commit_req_q   <= 1'b0;
            frame_seen_q   <= 1'b0;
            stat_changed_q <= 1'b0;
            irq_q          <= 1'b0;
            pulse_q        <= 1'b0;
            rdata_q        <= '0;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            sync3_q        <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < N_CTRL; k++) begin
                shadow_q[k] <= shadow_d[k];
                active_q[k] <= active_d[k];
            end
            for (int unsigned j = 0; j < N_STAT; j++)
                snap_q[j] <= snap_d[j];
            live_q         <= live_d;
            cfg_q          <= cfg_d;
            commit_req_q   <= commit_req_d;
            frame_seen_q   <= frame_seen_d;
            stat_changed_q <= stat_changed_d;
            irq_q          <= irq_d;
            pulse_q        <= pulse_d;
            rdata_q        <= rdata_d;
            sync1_q        <= iFrameToggle;
            sync2_q        <= sync1_q;
            sync3_q        <= sync2_q;
        end
    end

    always_comb begin
        oCtrl = '0;
        for (int unsigned k = 0; k < N_CTRL; k++)
            oCtrl[k*DATA_W +: DATA_W] = active_q[k];
    end

    assign Avalon_readdata = rdata_q;
    assign Avalon_irq      = irq_q;
    assign oCommitPulse    = pulse_q;

endmodule
